// File: rtl/dcache_pkg.sv
// Shared types and field geometry for the direct-mapped L1 data cache.
package dcache_pkg;

  localparam int unsigned OFFSET_W   = 4;
  localparam int unsigned INDEX_W    = 4;
  localparam int unsigned TAG_W      = 24;
  localparam int unsigned LINE_W     = 128;
  localparam int unsigned LINE_WORDS = 4;

  typedef enum logic [1:0] {
    TAG_CHECK  = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2
  } state_e;

endpackage

// File: rtl/dcache_array.sv
// Valid/dirty/tag/data storage: combinational read, synchronous word or line write.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_SETS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_W-1:0]    index,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_W-1:0]     rd_line,
  input  logic [LINE_WORDS-1:0] word_we,
  input  logic [31:0]           word_data,
  input  logic                  line_we,
  input  logic [TAG_W-1:0]      line_tag,
  input  logic [LINE_W-1:0]     line_data,
  input  logic                  clear_dirty
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_line  = data_q[index];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (|word_we) begin
      dirty_q[index] <= 1'b1;
    end else if (clear_dirty) begin
      dirty_q[index] <= 1'b0;
    end
  end

  // Tag and data contents need no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[index]  <= line_tag;
      data_q[index] <= line_data;
    end else begin
      for (int w = 0; w < LINE_WORDS; w++) begin
        if (word_we[w]) data_q[index][32*w +: 32] <= word_data;
      end
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate L1 data cache with a line-wide refill port.
module data_cache
  import dcache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_SETS   = 16,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     is_input_valid,
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [31:0]              din,
  output logic                     is_ready,
  output logic                     is_output_valid,
  output logic [31:0]              dout,
  output logic                     is_hit,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [LINE_WORDS*32-1:0] mem_wdata,
  input  logic                     mem_ack,
  input  logic [LINE_WORDS*32-1:0] mem_rdata
);

  state_e state_q, state_d;
  logic [TAG_W-1:0]   req_tag_q;
  logic [INDEX_W-1:0] req_index_q;
  logic               latch_req;

  logic [TAG_W-1:0]   a_tag;
  logic [INDEX_W-1:0] a_index;
  logic [1:0]         a_word;
  logic               unused_addr;

  assign a_tag       = addr[31:8];
  assign a_index     = addr[7:4];
  assign a_word      = addr[3:2];
  assign unused_addr = ^addr[1:0];

  logic [INDEX_W-1:0]    arr_index;
  logic                  rd_valid, rd_dirty;
  logic [TAG_W-1:0]      rd_tag;
  logic [LINE_W-1:0]     rd_line;
  logic [LINE_WORDS-1:0] word_we;
  logic                  line_we, clear_dirty;
  logic                  access, hit;

  // While a miss is outstanding the array is addressed by the latched request.
  assign arr_index = (state_q == TAG_CHECK) ? a_index : req_index_q;
  assign access    = is_input_valid & (mem_read | mem_write);
  assign hit       = rd_valid && (rd_tag == a_tag);

  dcache_array #(
    .NUM_SETS(NUM_SETS)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .index      (arr_index),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_tag     (rd_tag),
    .rd_line    (rd_line),
    .word_we    (word_we),
    .word_data  (din),
    .line_we    (line_we),
    .line_tag   (req_tag_q),
    .line_data  (mem_rdata),
    .clear_dirty(clear_dirty)
  );

  always_comb begin
    state_d         = state_q;
    is_ready        = 1'b0;
    is_output_valid = 1'b0;
    is_hit          = 1'b0;
    dout            = '0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    word_we         = '0;
    line_we         = 1'b0;
    clear_dirty     = 1'b0;
    latch_req       = 1'b0;
    unique case (state_q)
      TAG_CHECK: begin
        is_ready = 1'b1;
        if (access) begin
          if (hit) begin
            is_output_valid = 1'b1;
            is_hit          = 1'b1;
            dout            = rd_line[32*a_word +: 32];
            if (mem_write) word_we[a_word] = 1'b1;
          end else begin
            latch_req = 1'b1;
            state_d   = (rd_valid && rd_dirty) ? WRITE_BACK : ALLOCATE;
          end
        end
      end
      WRITE_BACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {rd_tag, req_index_q, 4'b0000};
        mem_wdata = rd_line;
        if (mem_ack) begin
          clear_dirty = 1'b1;
          state_d     = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag_q, req_index_q, 4'b0000};
        if (mem_ack) begin
          line_we = 1'b1;
          state_d = TAG_CHECK;
        end
      end
      default: state_d = TAG_CHECK;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= TAG_CHECK;
      req_tag_q   <= '0;
      req_index_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_req) begin
        req_tag_q   <= a_tag;
        req_index_q <= a_index;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: per-cycle compare against a set/line-level cache model.
module tb_data_cache;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         is_input_valid = 1'b0;
  logic [31:0]  addr = '0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [31:0]  din = '0;
  logic         is_ready, is_output_valid, is_hit, mem_req, mem_we;
  logic [31:0]  dout, mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ack;
  logic [127:0] mem_rdata;

  data_cache dut (
    .clk            (clk),
    .reset          (reset),
    .is_input_valid (is_input_valid),
    .addr           (addr),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .din            (din),
    .is_ready       (is_ready),
    .is_output_valid(is_output_valid),
    .dout           (dout),
    .is_hit         (is_hit),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0]  m_valid, m_dirty;
  logic [23:0]  m_tag  [16];
  logic [127:0] m_line [16];
  int           mphase;          // 0 idle, 1 writing back victim, 2 filling
  logic [3:0]   lidx;
  logic [23:0]  ltag;
  logic [127:0] mem [256];       // backing store indexed by line address bits [11:4]

  logic [3:0]  a_idx;
  logic [23:0] a_tag;
  logic [1:0]  a_w;
  logic        m_acc, m_hit;
  logic [31:0] m_word, exp_addr;
  assign a_idx    = addr[7:4];
  assign a_tag    = addr[31:8];
  assign a_w      = addr[3:2];
  assign m_acc    = is_input_valid & (mem_read | mem_write);
  assign m_hit    = m_acc && m_valid[a_idx] && (m_tag[a_idx] == a_tag);
  assign m_word   = m_line[a_idx][32*a_w +: 32];
  assign exp_addr = (mphase == 1) ? {m_tag[lidx], lidx, 4'h0} : {ltag, lidx, 4'h0};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid <= '0;
      m_dirty <= '0;
      mphase  <= 0;
    end else begin
      case (mphase)
        0: if (m_acc) begin
          if (m_hit) begin
            if (mem_write) begin
              m_line[a_idx][32*a_w +: 32] <= din;
              m_dirty[a_idx] <= 1'b1;
            end
          end else begin
            lidx   <= a_idx;
            ltag   <= a_tag;
            mphase <= (m_valid[a_idx] && m_dirty[a_idx]) ? 1 : 2;
          end
        end
        1: if (mem_ack) begin
          m_dirty[lidx] <= 1'b0;
          mphase <= 2;
        end
        default: if (mem_ack) begin
          m_line[lidx]  <= mem[{ltag[3:0], lidx}];
          m_tag[lidx]   <= ltag;
          m_valid[lidx] <= 1'b1;
          m_dirty[lidx] <= 1'b0;
          mphase <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (mphase == 0) begin
      chk("ready", is_ready, 1'b1);
      chk("out_valid", is_output_valid, m_hit);
      chk("hit", is_hit, m_hit);
      chk("mem_req", mem_req, 1'b0);
      chk("mem_we", mem_we, 1'b0);
      chk("mem_addr_idle", mem_addr, 32'h0);
      if (m_hit && mem_read) chk("dout", dout, m_word);
    end else begin
      chk("ready_busy", is_ready, 1'b0);
      chk("out_valid_busy", is_output_valid, 1'b0);
      chk("mem_req_busy", mem_req, 1'b1);
      chk("mem_we_busy", mem_we, mphase == 1);
      chk("mem_addr", mem_addr, exp_addr);
      if (mphase == 1) chk("mem_wdata", mem_wdata, m_line[lidx]);
    end
  end

  // ---------------- memory responder: ack 3 cycles after a request appears ----------------
  int           cnt;
  int           n_wb = 0, n_fill = 0;
  logic [31:0]  last_wb_addr, last_fill_addr;
  logic [127:0] last_wb_data;
  logic         stray = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++)
      for (int w = 0; w < 4; w++) mem[i][32*w +: 32] = {8'(i), 16'hA5A5, 8'(w)};
    mem[8'h10] = {32'd4, 32'd3, 32'd2, 32'd1};
    mem_ack   = 1'b0;
    mem_rdata = '0;
    cnt       = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset || mem_ack) begin
        mem_ack = 1'b0;
        cnt     = 0;
      end else if (mem_req) begin
        cnt++;
        if (cnt == 3) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            last_wb_addr = mem_addr;
            last_wb_data = mem_wdata;
            n_wb++;
            mem[{m_tag[lidx][3:0], lidx}] = m_line[lidx];
          end else begin
            last_fill_addr = mem_addr;
            mem_rdata = mem[mem_addr[11:4]];
            n_fill++;
          end
        end
      end else begin
        cnt = 0;
        if (stray) begin
          mem_ack   = 1'b1;
          mem_rdata = {128{1'b1}};
          stray     = 1'b0;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int          r_cyc;
  logic [31:0] r_dout;
  logic        r_hit;

  task automatic access(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] d);
    @(posedge clk);
    #2;
    addr = a; mem_read = rd; mem_write = wr; din = d; is_input_valid = 1'b1;
    r_cyc = 0;
    while (r_cyc < 64) begin
      @(negedge clk);
      #1;
      if (is_output_valid) break;
      r_cyc++;
    end
    if (r_cyc >= 64) begin
      checks++;
      errors++;
      $display("FAIL timeout: access %0h never completed within 64 cycles", a);
    end
    r_dout = dout;
    r_hit  = is_hit;
    @(posedge clk);
    #2;
    is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    int k;
    #1 reset = 1'b0;
    #2;
    chk("rst_ready", is_ready, 1'b1);
    chk("rst_valid", is_output_valid, 1'b0);
    chk("rst_hit", is_hit, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 128'h0);
    chk("rst_dout", dout, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;

    access(32'h100, 1, 0, 0);
    chk("cold_cycles", r_cyc, 4);
    chk("cold_dout", r_dout, 32'h1);
    chk("cold_hit", r_hit, 1'b1);
    chk("cold_fill_addr", last_fill_addr, 32'h100);
    chk("cold_no_wb", n_wb, 0);

    access(32'h104, 1, 0, 0);
    chk("hit104_cycles", r_cyc, 0);
    chk("hit104_dout", r_dout, 32'h2);

    access(32'h104, 1, 1, 32'h55);
    chk("rdwr_cycles", r_cyc, 0);
    access(32'h104, 1, 0, 0);
    chk("rdwr_readback", r_dout, 32'h55);

    access(32'h108, 0, 1, 32'hDEADBEEF);
    chk("st108_cycles", r_cyc, 0);
    access(32'h208, 1, 0, 0);
    chk("dirty_cycles", r_cyc, 8);
    chk("wb_addr", last_wb_addr, 32'h100);
    chk("wb_word2", last_wb_data[95:64], 32'hDEADBEEF);
    chk("wb_word1", last_wb_data[63:32], 32'h55);
    chk("fill_addr_200", last_fill_addr, 32'h200);
    chk("dout_208", r_dout, 32'h20A5A502);

    // A stray ack while idle must not disturb the resident line.
    @(posedge clk);
    #2 stray = 1'b1;
    repeat (3) @(posedge clk);
    access(32'h208, 1, 0, 0);
    chk("stray_cycles", r_cyc, 0);
    chk("stray_dout", r_dout, 32'h20A5A502);

    // Reset while a fill is outstanding.
    @(posedge clk);
    #2;
    addr = 32'h500; mem_read = 1'b1; mem_write = 1'b0; is_input_valid = 1'b1;
    k = 0;
    while (k < 20 && !(mem_req && !mem_we)) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("alloc_seen", mem_req && !mem_we, 1'b1);
    reset = 1'b0;
    is_input_valid = 1'b0; mem_read = 1'b0;
    #1;
    chk("midrst_req", mem_req, 1'b0);
    chk("midrst_ready", is_ready, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;

    access(32'h30C, 0, 1, 32'hCAFEF00D);
    chk("stmiss_cycles", r_cyc, 4);
    chk("stmiss_fill_addr", last_fill_addr, 32'h300);
    access(32'h30C, 1, 0, 0);
    chk("stmiss_readback", r_dout, 32'hCAFEF00D);

    access(32'h40C, 1, 0, 0);
    chk("conflict_cycles", r_cyc, 8);
    chk("conflict_wb_addr", last_wb_addr, 32'h300);
    chk("conflict_wb_word3", last_wb_data[127:96], 32'hCAFEF00D);
    chk("dout_40c", r_dout, 32'h40A5A503);

    access(32'h100, 1, 0, 0);
    chk("post_rst_cycles", r_cyc, 4);
    chk("post_rst_dout", r_dout, 32'h1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
